alu_muldiv_seq: RTL

Multi-cycle integer multiply/divide sequencer for the LEGv8 datapath. It owns the 64-bit ALU's operand and opcode inputs while busy. It computes MUL (low 64 bits of the unsigned product) by 64 shift-add iterations through the ALU's ADD operation. It computes UDIV (quotient and remainder) by 64 restoring iterations through the ALU's SUB operation. Sits beside the ALU in the execute stage; the pipeline control stalls on Busy and muxes the ALU ports to this block while Busy=1.

---
 rtl/alu_muldiv_seq_if.sv | 36 +++
 rtl/alu_muldiv_seq.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/alu_muldiv_seq_if.sv
// ----------------------------------------------------------------------------
// alu_muldiv_seq_if
// Bundles the request/response signals of the multiply/divide sequencer and
// its connection to the 64-bit ALU.
//   Request  : Start, Func (0=MUL, 1=UDIV), OpA, OpB
//   Response : Busy, Done, Result, Remainder
//   ALU side : AluOp, AluA, AluB, AluShamt (to ALU), AluOut (from ALU)
// Modports:
//   slave  - the sequencer itself
//   master - the pipeline control / ALU environment driving it
// ----------------------------------------------------------------------------
interface alu_muldiv_seq_if;
    logic        Start;
    logic        Func;
    logic [63:0] OpA;
    logic [63:0] OpB;
    logic        Busy;
    logic        Done;
    logic [63:0] Result;
    logic [63:0] Remainder;
    logic [3:0]  AluOp;
    logic [63:0] AluA;
    logic [63:0] AluB;
    logic [5:0]  AluShamt;
    logic [63:0] AluOut;

    modport slave (
        input  Start, Func, OpA, OpB, AluOut,
        output Busy, Done, Result, Remainder, AluOp, AluA, AluB, AluShamt
    );

    modport master (
        output Start, Func, OpA, OpB, AluOut,
        input  Busy, Done, Result, Remainder, AluOp, AluA, AluB, AluShamt
    );
endinterface

// File: rtl/alu_muldiv_seq.sv
// ----------------------------------------------------------------------------
// alu_muldiv_seq
// Multi-cycle unsigned multiply (low 64 bits) and unsigned divide sequencer.
// Borrows the execute-stage ALU while busy: MUL runs 64 shift-add steps
// through ALU ADD, UDIV runs 64 restoring steps through ALU SUB.
// Ports:
//   Clock   - rising-edge clock
//   Reset_n - asynchronous active-low reset
//   bus     - alu_muldiv_seq_if.slave (request, response and ALU signals)
// Latency: Start at edge E0 -> Done high in the cycle after E64.
// Divide by zero finishes immediately: Result = all ones, Remainder = OpA.
// ----------------------------------------------------------------------------
module alu_muldiv_seq (
    input  logic              Clock,
    input  logic              Reset_n,
    alu_muldiv_seq_if.slave   bus
);

    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0110;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    // acc_q    : MUL accumulator / UDIV partial remainder
    // mcand_q  : MUL multiplicand (shifts left) / UDIV divisor
    // mplier_q : MUL multiplier (shifts right) / UDIV dividend-quotient
    logic [1:0]  state_q,     state_d;
    logic [63:0] acc_q,       acc_d;
    logic [63:0] mcand_q,     mcand_d;
    logic [63:0] mplier_q,    mplier_d;
    logic [6:0]  cnt_q,       cnt_d;
    logic        func_q,      func_d;
    logic        busy_q,      busy_d;
    logic        done_q,      done_d;
    logic [63:0] result_q,    result_d;
    logic [63:0] remainder_q, remainder_d;

    // Restoring-division step: shift the next dividend bit into the partial
    // remainder. The bit shifted out (carry) means the shifted value is at
    // least 2^64 and therefore always exceeds the divisor; the ALU's
    // modulo-2^64 difference is still the correct new remainder then.
    logic [63:0] div_sh;
    logic        div_carry;
    logic        div_take;

    assign div_sh    = {acc_q[62:0], mplier_q[63]};
    assign div_carry = acc_q[63];
    assign div_take  = div_carry | (div_sh >= mcand_q);

    // ALU drive: only from registers, parked at ADD 0+0 outside RUN.
    always_comb begin
        bus.AluOp    = OP_ADD;
        bus.AluA     = 64'd0;
        bus.AluB     = 64'd0;
        bus.AluShamt = 6'd0;
        if (state_q == S_RUN) begin
            if (func_q) begin
                bus.AluOp = OP_SUB;
                bus.AluA  = div_sh;
                bus.AluB  = mcand_q;
            end else begin
                bus.AluOp = OP_ADD;
                bus.AluA  = acc_q;
                bus.AluB  = mplier_q[0] ? mcand_q : 64'd0;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        mcand_d     = mcand_q;
        mplier_d    = mplier_q;
        cnt_d       = cnt_q;
        func_d      = func_q;
        result_d    = result_q;
        remainder_d = remainder_q;

        case (state_q)
            // DONE lasts one cycle and accepts a new request exactly like
            // IDLE, which gives back-to-back operation without a gap.
            S_IDLE, S_DONE: begin
                state_d = S_IDLE;
                if (bus.Start) begin
                    func_d = bus.Func;
                    if (bus.Func && (bus.OpB == 64'd0)) begin
                        state_d     = S_DONE;
                        result_d    = {64{1'b1}};
                        remainder_d = bus.OpA;
                    end else begin
                        state_d = S_RUN;
                        acc_d   = 64'd0;
                        cnt_d   = 7'd0;
                        if (bus.Func) begin
                            mplier_d = bus.OpA;
                            mcand_d  = bus.OpB;
                        end else begin
                            mcand_d  = bus.OpA;
                            mplier_d = bus.OpB;
                        end
                    end
                end
            end

            S_RUN: begin
                if (func_q) begin
                    acc_d    = div_take ? bus.AluOut : div_sh;
                    mplier_d = {mplier_q[62:0], div_take};
                end else begin
                    acc_d    = bus.AluOut;
                    mcand_d  = mcand_q << 1;
                    mplier_d = mplier_q >> 1;
                end
                cnt_d = cnt_q + 7'd1;
                // Results capture the outcome of the 64th step itself.
                if (cnt_q == 7'd63) begin
                    state_d     = S_DONE;
                    result_d    = func_q ? mplier_d : acc_d;
                    remainder_d = func_q ? acc_d : 64'd0;
                end
            end

            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q     <= S_IDLE;
            acc_q       <= 64'd0;
            mcand_q     <= 64'd0;
            mplier_q    <= 64'd0;
            cnt_q       <= 7'd0;
            func_q      <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            result_q    <= 64'd0;
            remainder_q <= 64'd0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            mcand_q     <= mcand_d;
            mplier_q    <= mplier_d;
            cnt_q       <= cnt_d;
            func_q      <= func_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            result_q    <= result_d;
            remainder_q <= remainder_d;
        end
    end

    assign bus.Busy      = busy_q;
    assign bus.Done      = done_q;
    assign bus.Result    = result_q;
    assign bus.Remainder = remainder_q;

endmodule
